// File: rtl/sniffer_wr_fifo.sv
// Posted-write buffer between the sniffer Wishbone master and sample RAM port A.
// Acks writes on acceptance, replays them in order into a stallable RAM port.
module sniffer_wr_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 14,
    parameter int LVL_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       s_addr_i,
    input  logic [31:0]       s_data_i,
    input  logic [3:0]        s_sel_i,
    input  logic              s_we_i,
    input  logic              s_stb_i,
    output logic              s_stall_o,
    output logic              s_ack_o,
    output logic              m_en_o,
    output logic              m_we_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [31:0]       m_data_o,
    output logic [3:0]        m_sel_o,
    input  logic              m_stall_i,
    output logic [LVL_W-1:0]  level_o,
    output logic [LVL_W-1:0]  hwm_o,
    input  logic              hwm_clr_i,
    output logic              idle_o
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        sel;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] level_next;
    logic [LVL_W-1:0] hwm;
    logic             ack;
    logic             full;
    logic             empty;
    logic             accept;
    logic             push;
    logic             pop;
    logic             unused_addr;

    assign unused_addr = ^s_addr_i[31:ADDR_W];

    // Full comes from the registered count only: a same-cycle pop
    // never frees a slot for a push.
    assign full   = (level == LVL_W'(DEPTH));
    assign empty  = (level == '0);
    assign accept = s_stb_i & ~full;
    assign push   = accept & s_we_i;
    assign pop    = ~empty & ~m_stall_i;

    always_comb begin
        level_next = level;
        unique case ({push, pop})
            2'b10:   level_next = level + LVL_W'(1);
            2'b01:   level_next = level - LVL_W'(1);
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            hwm    <= '0;
            ack    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level_next;
            ack   <= accept;
            // Clearing loads the current fill so it is never under-reported.
            if (hwm_clr_i || (level_next > hwm))
                hwm <= level_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr] <= '{addr: s_addr_i[ADDR_W-1:0],
                             data: s_data_i,
                             sel:  s_sel_i};
    end

    // Gating on empty keeps the RAM side at zero in and after reset.
    assign head     = mem[rd_ptr];
    assign m_en_o   = ~empty;
    assign m_we_o   = ~empty;
    assign m_addr_o = empty ? '0 : head.addr;
    assign m_data_o = empty ? '0 : head.data;
    assign m_sel_o  = empty ? '0 : head.sel;

    assign s_stall_o = full;
    assign s_ack_o   = ack;
    assign level_o   = level;
    assign hwm_o     = hwm;
    assign idle_o    = empty & ~ack;

endmodule

// File: tb/tb_sniffer_wr_fifo.sv
// Self-checking bench for sniffer_wr_fifo: queue model checked every
// cycle plus directed scenarios with literal expectations.
module tb_sniffer_wr_fifo;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 14;
    localparam int LVL_W  = 4;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic [31:0]       s_addr_i = '0;
    logic [31:0]       s_data_i = '0;
    logic [3:0]        s_sel_i = '0;
    logic              s_we_i = 1'b0;
    logic              s_stb_i = 1'b0;
    logic              s_stall_o;
    logic              s_ack_o;
    logic              m_en_o;
    logic              m_we_o;
    logic [ADDR_W-1:0] m_addr_o;
    logic [31:0]       m_data_o;
    logic [3:0]        m_sel_o;
    logic              m_stall_i = 1'b0;
    logic [LVL_W-1:0]  level_o;
    logic [LVL_W-1:0]  hwm_o;
    logic              hwm_clr_i = 1'b0;
    logic              idle_o;

    sniffer_wr_fifo #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LVL_W(LVL_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_addr_i(s_addr_i), .s_data_i(s_data_i),
        .s_sel_i(s_sel_i), .s_we_i(s_we_i),
        .s_stb_i(s_stb_i), .s_stall_o(s_stall_o),
        .s_ack_o(s_ack_o), .m_en_o(m_en_o),
        .m_we_o(m_we_o), .m_addr_o(m_addr_o),
        .m_data_o(m_data_o), .m_sel_o(m_sel_o),
        .m_stall_i(m_stall_i), .level_o(level_o),
        .hwm_o(hwm_o), .hwm_clr_i(hwm_clr_i),
        .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
        logic [3:0]        s;
    } ent_t;

    int   n_chk = 0;
    int   n_fail = 0;
    int   ack_seen = 0;
    int   wr_seen = 0;
    ent_t q[$];
    logic exp_ack = 1'b0;
    int   exp_hwm = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: sample outputs at negedge, then advance with the inputs
    // that the next posedge will see.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                q.delete();
                exp_ack = 1'b0;
                exp_hwm = 0;
                chk("rst_level", 64'(level_o), 0);
                chk("rst_hwm", 64'(hwm_o), 0);
                chk("rst_ack", 64'(s_ack_o), 0);
                chk("rst_stall", 64'(s_stall_o), 0);
                chk("rst_en", 64'(m_en_o), 0);
                chk("rst_we", 64'(m_we_o), 0);
                chk("rst_idle", 64'(idle_o), 1);
                chk("rst_addr", 64'(m_addr_o), 0);
                chk("rst_data", 64'(m_data_o), 0);
                chk("rst_sel", 64'(m_sel_o), 0);
            end else begin
                int   sz;
                logic acc;
                sz = q.size();
                chk("ack", 64'(s_ack_o), 64'(exp_ack));
                chk("stall", 64'(s_stall_o), 64'(sz == DEPTH));
                chk("en", 64'(m_en_o), 64'(sz != 0));
                chk("we", 64'(m_we_o), 64'(sz != 0));
                chk("level", 64'(level_o), 64'(sz));
                chk("hwm", 64'(hwm_o), 64'(exp_hwm));
                chk("idle", 64'(idle_o), 64'(sz == 0 && !exp_ack));
                if (sz != 0) begin
                    chk("m_addr", 64'(m_addr_o), 64'(q[0].a));
                    chk("m_data", 64'(m_data_o), 64'(q[0].d));
                    chk("m_sel", 64'(m_sel_o), 64'(q[0].s));
                end
                if (s_ack_o)
                    ack_seen++;
                if (m_en_o && !m_stall_i)
                    wr_seen++;
                acc = s_stb_i && (sz != DEPTH);
                if (sz != 0 && !m_stall_i)
                    void'(q.pop_front());
                if (acc && s_we_i)
                    q.push_back('{a: s_addr_i[ADDR_W-1:0],
                                  d: s_data_i, s: s_sel_i});
                exp_ack = acc;
                if (hwm_clr_i || q.size() > exp_hwm)
                    exp_hwm = q.size();
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        s_stb_i  = 1'b1;
        s_we_i   = we;
        s_addr_i = a;
        s_data_i = d;
        s_sel_i  = s;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        int n;
        set_req(1'b1, a, d, s);
        n = 0;
        while (s_stall_o && n < 50) begin
            step();
            n++;
        end
        if (n >= 50)
            chk("accept_timeout", 64'(n), 0);
        step();
    endtask

    task automatic idle_bus();
        s_stb_i = 1'b0;
        s_we_i  = 1'b0;
    endtask

    task automatic drain();
        int n;
        idle_bus();
        m_stall_i = 1'b0;
        n = 0;
        while (level_o != 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain_timeout", 64'(n < 100), 1);
        step();
    endtask

    int ack0;
    int wr0;

    initial begin
        step();
        step();
        rst_i = 1'b1;
        step();

        chk("t0_idle", 64'(idle_o), 1);
        chk("t0_level", 64'(level_o), 0);

        // Single write, free-running RAM port
        wr(32'h0000_1234, 32'hDEAD_BEEF, 4'hF);
        idle_bus();
        chk("t1_ack", 64'(s_ack_o), 1);
        chk("t1_en", 64'(m_en_o), 1);
        chk("t1_addr", 64'(m_addr_o), 64'h1234);
        chk("t1_data", 64'(m_data_o), 64'hDEAD_BEEF);
        step();
        chk("t1_level0", 64'(level_o), 0);
        chk("t1_idle", 64'(idle_o), 1);

        // Fill to full behind a stalled RAM, then drain
        ack0 = ack_seen;
        wr0 = wr_seen;
        m_stall_i = 1'b1;
        for (int i = 0; i < 8; i++)
            wr(32'hABCD_0100 + i, 32'h1000_0000 + i, 4'(i + 1));
        set_req(1'b1, 32'hABCD_0108, 32'h1000_0008, 4'h3);
        chk("t2_stall", 64'(s_stall_o), 1);
        chk("t2_level", 64'(level_o), 8);
        chk("t2_hwm", 64'(hwm_o), 8);
        step();
        step();
        chk("t2_stall_hold", 64'(s_stall_o), 1);
        chk("t2_en_hold", 64'(m_en_o), 1);
        chk("t2_addr_hold", 64'(m_addr_o), 64'h0100);
        chk("t2_acks8", 64'(ack_seen - ack0), 8);
        m_stall_i = 1'b0;
        wr(32'hABCD_0108, 32'h1000_0008, 4'h3);
        wr(32'hABCD_0109, 32'h1000_0009, 4'h6);
        drain();
        chk("t2_acks10", 64'(ack_seen - ack0), 10);
        chk("t2_writes10", 64'(wr_seen - wr0), 10);

        // Steady push+pop at level 3 across several wraps
        m_stall_i = 1'b1;
        for (int i = 0; i < 3; i++)
            wr(32'h0000_2000 + i, 32'h2000_0000 + i, 4'hC);
        m_stall_i = 1'b0;
        for (int i = 3; i < 23; i++) begin
            wr(32'h0000_2000 + i, 32'h2000_0000 + i, 4'(i));
            chk("t3_level3", 64'(level_o), 3);
        end
        drain();

        // Read request between two writes
        ack0 = ack_seen;
        wr0 = wr_seen;
        wr(32'h0000_3001, 32'h3333_0001, 4'h1);
        set_req(1'b0, 32'h0000_3FFF, 32'hFFFF_FFFF, 4'hF);
        step();
        wr(32'h0000_3002, 32'h3333_0002, 4'h2);
        drain();
        step();
        chk("t4_acks", 64'(ack_seen - ack0), 3);
        chk("t4_writes", 64'(wr_seen - wr0), 2);

        // High-water clear at level 2 after a peak of 6
        hwm_clr_i = 1'b1;
        step();
        hwm_clr_i = 1'b0;
        chk("t5_hwm_zero", 64'(hwm_o), 0);
        m_stall_i = 1'b1;
        for (int i = 0; i < 6; i++)
            wr(32'h0000_0500 + i, 32'h5000_0000 + i, 4'h5);
        idle_bus();
        chk("t5_peak6", 64'(hwm_o), 6);
        m_stall_i = 1'b0;
        for (int i = 0; i < 4; i++)
            step();
        m_stall_i = 1'b1;
        hwm_clr_i = 1'b1;
        chk("t5_level2", 64'(level_o), 2);
        step();
        hwm_clr_i = 1'b0;
        chk("t5_hwm_clr", 64'(hwm_o), 2);
        wr(32'h0000_0510, 32'h5000_0010, 4'h5);
        wr(32'h0000_0511, 32'h5000_0011, 4'h5);
        idle_bus();
        step();
        chk("t5_peak4", 64'(hwm_o), 4);
        drain();

        // Asynchronous reset mid-burst
        m_stall_i = 1'b1;
        for (int i = 0; i < 5; i++)
            wr(32'h0000_0600 + i, 32'h6000_0000 + i, 4'h6);
        set_req(1'b1, 32'h0000_0605, 32'h6000_0005, 4'h6);
        chk("t6_level5", 64'(level_o), 5);
        rst_i = 1'b0;
        #1;
        chk("t6_rst_level", 64'(level_o), 0);
        chk("t6_rst_en", 64'(m_en_o), 0);
        chk("t6_rst_ack", 64'(s_ack_o), 0);
        chk("t6_rst_idle", 64'(idle_o), 1);
        step();
        step();
        rst_i = 1'b1;
        idle_bus();
        m_stall_i = 1'b0;
        wr(32'h0000_0ABC, 32'hCAFE_F00D, 4'h9);
        idle_bus();
        chk("t6_new_en", 64'(m_en_o), 1);
        chk("t6_new_addr", 64'(m_addr_o), 64'h0ABC);
        chk("t6_new_data", 64'(m_data_o), 64'hCAFE_F00D);
        chk("t6_new_level", 64'(level_o), 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
